// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and responder state codes.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_ERR1 = 3'd3;
    localparam logic [2:0] ST_ERR2 = 3'd4;

endpackage

// File: rtl/ahb_byte_strobe.sv
// Little-endian byte-lane enables for an AHB transfer.
module ahb_byte_strobe
    import ahb_pkg::*;
(
    input  logic [2:0] size,
    input  logic [1:0] lane,
    output logic [3:0] be
);

    always_comb begin
        be = 4'b0000;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << lane;
            HSIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: be = 4'b1111;
            default:    be = 4'b0000;
        endcase
    end

endmodule

// File: rtl/ahb_sram_responder.sv
// AHB-Lite SRAM responder with fixed wait states and two-cycle ERROR.
module ahb_sram_responder
    import ahb_pkg::*;
#(
    parameter int MEM_DEPTH   = 64,
    parameter int WAIT_STATES = 1
) (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic        Hsel,
    input  logic [31:0] Haddr,
    input  logic        Hwrite,
    input  logic [2:0]  Hsize,
    input  logic [2:0]  Hburst,
    input  logic [3:0]  Hprot,
    input  logic [1:0]  Htrans,
    input  logic        Hready,
    input  logic [31:0] Hwdata,
    output logic        Hready_out,
    output logic        Hresp,
    output logic [31:0] Hrdata
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [2:0]    state;
    logic [2:0]    nxt;
    logic [3:0]    cnt;
    logic [AW-1:0] addr_q;
    logic          wr_q;
    logic [2:0]    size_q;
    logic [1:0]    lane_q;
    logic [3:0]    be_q;
    logic          open;
    logic          accept;
    logic          bad;
    logic          commit;
    logic          rd_go;
    logic [AW-1:0] rd_idx;
    logic [31:0]   rd_word;
    logic [31:0]   mem [MEM_DEPTH];

    logic unused;
    assign unused = ^{Hburst, Hprot, Htrans[0]};

    ahb_byte_strobe u_strobe (
        .size (size_q),
        .lane (lane_q),
        .be   (be_q)
    );

    assign open   = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
    assign accept = open && Hsel && Hready && Htrans[1];
    assign commit = (state == ST_DATA) && wr_q;

    always_comb begin
        bad = 1'b0;
        case (Hsize)
            HSIZE_BYTE: bad = 1'b0;
            HSIZE_HALF: bad = Haddr[0];
            HSIZE_WORD: bad = |Haddr[1:0];
            default:    bad = 1'b1;
        endcase
        if ({2'b00, Haddr[31:2]} >= 32'(MEM_DEPTH))
            bad = 1'b1;
    end

    always_comb begin
        nxt = ST_IDLE;
        case (state)
            ST_WAIT: nxt = (cnt == 4'd0) ? ST_DATA : ST_WAIT;
            ST_ERR1: nxt = ST_ERR2;
            default: begin
                if (accept && bad)
                    nxt = ST_ERR1;
                else if (accept)
                    nxt = (WAIT_STATES == 0) ? ST_DATA : ST_WAIT;
            end
        endcase
    end

    // Zero-wait reads sample memory on the accept edge, so a write
    // committing on that same edge must be forwarded byte by byte.
    assign rd_idx = accept ? Haddr[AW+1:2] : addr_q;
    assign rd_go  = (nxt == ST_DATA) && (accept ? !Hwrite : !wr_q);

    always_comb begin
        rd_word = mem[rd_idx];
        if (commit && (addr_q == rd_idx)) begin
            for (int b = 0; b < 4; b++)
                if (be_q[b])
                    rd_word[8*b +: 8] = Hwdata[8*b +: 8];
        end
    end

    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            size_q     <= 3'd0;
            lane_q     <= 2'd0;
            Hready_out <= 1'b1;
            Hresp      <= HRESP_OKAY;
            Hrdata     <= 32'h0;
        end else begin
            state      <= nxt;
            Hready_out <= !((nxt == ST_WAIT) || (nxt == ST_ERR1));
            Hresp      <= (nxt == ST_ERR1) || (nxt == ST_ERR2);
            Hrdata     <= rd_go ? rd_word : 32'h0;
            if (accept) begin
                addr_q <= Haddr[AW+1:2];
                wr_q   <= Hwrite;
                size_q <= Hsize;
                lane_q <= Haddr[1:0];
            end
            if (accept && !bad && (WAIT_STATES > 0))
                cnt <= 4'(WAIT_STATES - 1);
            else if ((state == ST_WAIT) && (cnt != 4'd0))
                cnt <= cnt - 4'd1;
        end
    end

    // Storage has no reset; a reset edge suppresses a pending commit.
    always_ff @(posedge Hclk) begin
        if (Hresetn && commit) begin
            for (int b = 0; b < 4; b++)
                if (be_q[b])
                    mem[addr_q][8*b +: 8] <= Hwdata[8*b +: 8];
        end
    end

endmodule

// File: tb/tb_ahb_sram_responder.sv
// Directed bench: one WAIT_STATES=1 and one WAIT_STATES=0 responder.
module tb_ahb_sram_responder;

    logic        clk;
    logic        rst_n;
    logic        sel1;
    logic        sel0;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic        rdy1;
    logic        resp1;
    logic [31:0] rdata1;
    logic        rdy0;
    logic        resp0;
    logic [31:0] rdata0;

    int n_cmp = 0;
    int n_bad = 0;

    ahb_sram_responder #(.MEM_DEPTH(64), .WAIT_STATES(1)) u_ws1 (
        .Hclk       (clk),
        .Hresetn    (rst_n),
        .Hsel       (sel1),
        .Haddr      (haddr),
        .Hwrite     (hwrite),
        .Hsize      (hsize),
        .Hburst     (hburst),
        .Hprot      (hprot),
        .Htrans     (htrans),
        .Hready     (rdy1),
        .Hwdata     (hwdata),
        .Hready_out (rdy1),
        .Hresp      (resp1),
        .Hrdata     (rdata1)
    );

    ahb_sram_responder #(.MEM_DEPTH(64), .WAIT_STATES(0)) u_ws0 (
        .Hclk       (clk),
        .Hresetn    (rst_n),
        .Hsel       (sel0),
        .Haddr      (haddr),
        .Hwrite     (hwrite),
        .Hsize      (hsize),
        .Hburst     (hburst),
        .Hprot      (hprot),
        .Htrans     (htrans),
        .Hready     (rdy0),
        .Hwdata     (hwdata),
        .Hready_out (rdy0),
        .Hresp      (resp0),
        .Hrdata     (rdata0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic addr_ph(input logic s1, input logic s0, input logic [1:0] tr,
                           input logic [31:0] a, input logic w, input logic [2:0] sz);
        sel1   = s1;
        sel0   = s0;
        htrans = tr;
        haddr  = a;
        hwrite = w;
        hsize  = sz;
    endtask

    // Single non-pipelined transfer on the WAIT_STATES=1 responder.
    task automatic xfer1(input logic [1:0] tr, input logic [31:0] a, input logic w,
                         input logic [2:0] sz, input logic [31:0] wd,
                         output int nw, output logic r1, output logic rl,
                         output logic [31:0] rd, output logic to);
        addr_ph(1'b1, 1'b0, tr, a, w, sz);
        hburst = 3'($urandom);
        hprot  = 4'($urandom);
        @(posedge clk); #1;
        addr_ph(1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 3'd0);
        hwdata = wd;
        nw = 0; r1 = 1'b0; rl = 1'b0; rd = 32'h0; to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) r1 = resp1;
            if (rdy1) begin
                rl = resp1;
                rd = rdata1;
                to = 1'b0;
                break;
            end
            nw++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++; if (rdy1 !== 1'b1) begin n_bad++; $display("FAIL reset_rdy1 got=%b exp=1", rdy1); end
        n_cmp++; if (resp1 !== 1'b0) begin n_bad++; $display("FAIL reset_resp1 got=%b exp=0", resp1); end
        n_cmp++; if (rdata1 !== 32'h0) begin n_bad++; $display("FAIL reset_rdata1 got=%h exp=0", rdata1); end
        n_cmp++; if (rdy0 !== 1'b1) begin n_bad++; $display("FAIL reset_rdy0 got=%b exp=1", rdy0); end
        n_cmp++; if (resp0 !== 1'b0) begin n_bad++; $display("FAIL reset_resp0 got=%b exp=0", resp0); end
        n_cmp++; if (rdata0 !== 32'h0) begin n_bad++; $display("FAIL reset_rdata0 got=%h exp=0", rdata0); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_word_rw;
        int nw; logic r1; logic rl; logic [31:0] rd; logic to;
        xfer1(2'b10, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF, nw, r1, rl, rd, to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL wr_timeout got=%b exp=0", to); end
        n_cmp++; if (nw != 1) begin n_bad++; $display("FAIL wr_waits got=%0d exp=1", nw); end
        n_cmp++; if (rl !== 1'b0) begin n_bad++; $display("FAIL wr_resp got=%b exp=0", rl); end
        xfer1(2'b10, 32'h10, 1'b0, 3'd2, 32'h0, nw, r1, rl, rd, to);
        n_cmp++; if (nw != 1) begin n_bad++; $display("FAIL rd_waits got=%0d exp=1", nw); end
        n_cmp++; if (rl !== 1'b0) begin n_bad++; $display("FAIL rd_resp got=%b exp=0", rl); end
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
        @(negedge clk);
        n_cmp++; if (rdata1 !== 32'h0) begin n_bad++; $display("FAIL idle_rdata got=%h exp=0", rdata1); end
        @(posedge clk); #1;
    endtask

    task automatic test_byte_lanes;
        int nw; logic r1; logic rl; logic [31:0] rd; logic to;
        xfer1(2'b10, 32'h10, 1'b1, 3'd2, 32'h00000000, nw, r1, rl, rd, to);
        xfer1(2'b10, 32'h11, 1'b1, 3'd0, 32'h1122AA44, nw, r1, rl, rd, to);
        n_cmp++; if (rl !== 1'b0) begin n_bad++; $display("FAIL byte_resp got=%b exp=0", rl); end
        xfer1(2'b10, 32'h10, 1'b0, 3'd2, 32'h0, nw, r1, rl, rd, to);
        n_cmp++; if (rd !== 32'h0000AA00) begin n_bad++; $display("FAIL byte_data got=%h exp=0000aa00", rd); end
        xfer1(2'b10, 32'h12, 1'b1, 3'd1, 32'hBEEF5566, nw, r1, rl, rd, to);
        xfer1(2'b10, 32'h10, 1'b0, 3'd2, 32'h0, nw, r1, rl, rd, to);
        n_cmp++; if (rd !== 32'hBEEFAA00) begin n_bad++; $display("FAIL half_data got=%h exp=beefaa00", rd); end
    endtask

    task automatic test_misaligned;
        int nw; logic r1; logic rl; logic [31:0] rd; logic to;
        xfer1(2'b10, 32'h12, 1'b0, 3'd2, 32'h0, nw, r1, rl, rd, to);
        n_cmp++; if (r1 !== 1'b1) begin n_bad++; $display("FAIL mis_err1_resp got=%b exp=1", r1); end
        n_cmp++; if (nw != 1) begin n_bad++; $display("FAIL mis_err1_len got=%0d exp=1", nw); end
        n_cmp++; if (rl !== 1'b1) begin n_bad++; $display("FAIL mis_err2_resp got=%b exp=1", rl); end
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL mis_rdata got=%h exp=0", rd); end
        xfer1(2'b10, 32'h12, 1'b1, 3'd2, 32'hFFFFFFFF, nw, r1, rl, rd, to);
        n_cmp++; if (rl !== 1'b1) begin n_bad++; $display("FAIL mis_wr_resp got=%b exp=1", rl); end
        xfer1(2'b10, 32'h13, 1'b1, 3'd1, 32'hFFFFFFFF, nw, r1, rl, rd, to);
        n_cmp++; if (rl !== 1'b1) begin n_bad++; $display("FAIL mis_half_resp got=%b exp=1", rl); end
        xfer1(2'b10, 32'h10, 1'b1, 3'd3, 32'hFFFFFFFF, nw, r1, rl, rd, to);
        n_cmp++; if (rl !== 1'b1) begin n_bad++; $display("FAIL bad_size_resp got=%b exp=1", rl); end
        xfer1(2'b10, 32'h10, 1'b0, 3'd2, 32'h0, nw, r1, rl, rd, to);
        n_cmp++; if (rd !== 32'hBEEFAA00) begin n_bad++; $display("FAIL mis_unchanged got=%h exp=beefaa00", rd); end
        n_cmp++; if (rl !== 1'b0) begin n_bad++; $display("FAIL mis_after_resp got=%b exp=0", rl); end
    endtask

    task automatic test_err_pipeline;
        int nw; logic r1; logic rl; logic [31:0] rd; logic to;
        xfer1(2'b11, 32'h0, 1'b1, 3'd2, 32'h01020304, nw, r1, rl, rd, to);
        n_cmp++; if (rl !== 1'b0) begin n_bad++; $display("FAIL seq_resp got=%b exp=0", rl); end
        addr_ph(1'b1, 1'b0, 2'b10, 32'h100, 1'b0, 3'd2);
        @(posedge clk); #1;
        addr_ph(1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 3'd0);
        @(negedge clk);
        n_cmp++; if ({rdy1, resp1} !== 2'b01) begin n_bad++; $display("FAIL oor_err1 got=%b exp=01", {rdy1, resp1}); end
        @(posedge clk); #1;
        addr_ph(1'b1, 1'b0, 2'b10, 32'h0, 1'b0, 3'd2);
        @(negedge clk);
        n_cmp++; if ({rdy1, resp1} !== 2'b11) begin n_bad++; $display("FAIL oor_err2 got=%b exp=11", {rdy1, resp1}); end
        @(posedge clk); #1;
        addr_ph(1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 3'd0);
        @(negedge clk);
        n_cmp++; if ({rdy1, resp1} !== 2'b00) begin n_bad++; $display("FAIL oor_next_wait got=%b exp=00", {rdy1, resp1}); end
        n_cmp++; if (rdata1 !== 32'h0) begin n_bad++; $display("FAIL oor_wait_rdata got=%h exp=0", rdata1); end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if ({rdy1, resp1} !== 2'b10) begin n_bad++; $display("FAIL oor_next_data got=%b exp=10", {rdy1, resp1}); end
        n_cmp++; if (rdata1 !== 32'h01020304) begin n_bad++; $display("FAIL oor_next_rdata got=%h exp=01020304", rdata1); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic [31:0] wa [8];
        logic        wr [8];
        logic [31:0] d  [4];
        logic [31:0] ex;
        wa = '{32'h0, 32'h4, 32'h8, 32'hC, 32'hC, 32'h0, 32'h4, 32'h8};
        wr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        d  = '{32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888};
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) addr_ph(1'b0, 1'b1, 2'b10, wa[i], wr[i], 3'd2);
            else addr_ph(1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 3'd0);
            hwdata = 32'h0;
            ex = 32'h0;
            if (i >= 1) begin
                if (wr[i-1]) hwdata = d[i-1];
                else ex = d[wa[i-1][3:2]];
            end
            @(negedge clk);
            if (i >= 1) begin
                n_cmp++; if (rdy0 !== 1'b1) begin n_bad++; $display("FAIL b2b_rdy slot=%0d got=%b exp=1", i-1, rdy0); end
                n_cmp++; if (resp0 !== 1'b0) begin n_bad++; $display("FAIL b2b_resp slot=%0d got=%b exp=0", i-1, resp0); end
                n_cmp++; if (rdata0 !== ex) begin n_bad++; $display("FAIL b2b_rdata slot=%0d got=%h exp=%h", i-1, rdata0, ex); end
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_cmp++; if (rdata0 !== 32'h0) begin n_bad++; $display("FAIL b2b_idle_rdata got=%h exp=0", rdata0); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort;
        int nw; logic r1; logic rl; logic [31:0] rd; logic to;
        xfer1(2'b10, 32'h20, 1'b1, 3'd2, 32'h11111111, nw, r1, rl, rd, to);
        addr_ph(1'b1, 1'b0, 2'b10, 32'h20, 1'b1, 3'd2);
        @(posedge clk); #1;
        addr_ph(1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 3'd0);
        hwdata = 32'h12345678;
        rst_n  = 1'b0;
        @(negedge clk);
        n_cmp++; if (rdy1 !== 1'b0) begin n_bad++; $display("FAIL abort_wait_rdy got=%b exp=0", rdy1); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if ({rdy1, resp1} !== 2'b10) begin n_bad++; $display("FAIL abort_outputs got=%b exp=10", {rdy1, resp1}); end
        n_cmp++; if (rdata1 !== 32'h0) begin n_bad++; $display("FAIL abort_rdata got=%h exp=0", rdata1); end
        @(posedge clk); #1;
        xfer1(2'b10, 32'h20, 1'b0, 3'd2, 32'h0, nw, r1, rl, rd, to);
        n_cmp++; if (rd !== 32'h11111111) begin n_bad++; $display("FAIL abort_mem got=%h exp=11111111", rd); end
    endtask

    initial begin
        rst_n  = 1'b0;
        sel1   = 1'b0;
        sel0   = 1'b0;
        haddr  = 32'h0;
        hwrite = 1'b0;
        hsize  = 3'd0;
        hburst = 3'd0;
        hprot  = 4'd0;
        htrans = 2'b00;
        hwdata = 32'h0;
        test_reset();
        test_word_rw();
        test_byte_lanes();
        test_misaligned();
        test_err_pipeline();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
